// File: rtl/cache_trace_stats.sv
// cache_trace_stats: per-channel cache access tracer. Each channel classifies
// new accesses as hit/miss, times miss service with a two-state FSM and keeps
// saturating event counters. Counters are read through a registered mux.
module cache_trace_stats #(
  parameter int NCH    = 2,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16,
  parameter int LAT_W  = 8,
  localparam int RD_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        enable,
  input  logic                  halt,
  input  logic                  clr,
  input  logic [NCH*ADDR_W-1:0] addr,
  input  logic [NCH-1:0]        stall,
  output logic [NCH-1:0]        req,
  output logic [NCH-1:0]        hit,
  output logic [NCH-1:0]        miss,
  output logic [NCH-1:0]        busy,
  input  logic [RD_W-1:0]       rd_ch,
  input  logic [1:0]            rd_sel,
  output logic [CNT_W-1:0]      rd_data
);

  typedef enum logic {IDLE = 1'b0, MISS = 1'b1} state_t;

  logic                   halted_reg;
  logic [NCH*CNT_W-1:0]   req_cnt_flat;
  logic [NCH*CNT_W-1:0]   miss_cnt_flat;
  logic [NCH*CNT_W-1:0]   stall_cnt_flat;
  logic [NCH*LAT_W-1:0]   max_lat_flat;
  logic [CNT_W-1:0]       rd_data_next;
  logic [CNT_W-1:0]       rd_data_reg;

  // Sticky freeze: once the core halts, tracing stays frozen until reset.
  always_ff @(posedge clk) begin
    if (rst) halted_reg <= 1'b0;
    else if (halt) halted_reg <= 1'b1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [ADDR_W-1:0] addr_cur;
      logic [ADDR_W-1:0] addr_d_reg;
      logic              rst_d_reg;
      state_t            state_reg, state_next;
      logic [LAT_W-1:0]  lat_reg, lat_next;
      logic [LAT_W-1:0]  max_lat_reg, max_lat_next;
      logic [CNT_W-1:0]  req_cnt_reg, req_cnt_next;
      logic [CNT_W-1:0]  miss_cnt_reg, miss_cnt_next;
      logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;
      logic              track, chg, req_c, hit_c, miss_c;

      assign addr_cur = addr[gi*ADDR_W +: ADDR_W];

      // Access classification; the first cycle after reset always counts as
      // a new access, and nothing is classified while a miss is outstanding.
      always_comb begin
        track  = ~rst & enable[gi] & ~halted_reg & ~halt;
        chg    = (addr_cur != addr_d_reg);
        req_c  = (state_reg == IDLE) & track & (rst_d_reg | chg);
        hit_c  = req_c & ~stall[gi];
        miss_c = req_c & stall[gi];
      end

      // Miss FSM, latency timing and saturating counters; clr overrides all.
      always_comb begin
        state_next     = state_reg;
        lat_next       = lat_reg;
        max_lat_next   = max_lat_reg;
        req_cnt_next   = req_cnt_reg;
        miss_cnt_next  = miss_cnt_reg;
        stall_cnt_next = stall_cnt_reg;
        case (state_reg)
          IDLE: begin
            if (miss_c) begin
              state_next = MISS;
              lat_next   = LAT_W'(1);
            end
          end
          MISS: begin
            if (!track) begin
              state_next = IDLE;
            end else if (stall[gi]) begin
              if (!(&lat_reg)) lat_next = lat_reg + LAT_W'(1);
            end else begin
              state_next = IDLE;
              if (lat_reg > max_lat_reg) max_lat_next = lat_reg;
            end
          end
          default: state_next = IDLE;
        endcase
        if (req_c && !(&req_cnt_reg)) req_cnt_next = req_cnt_reg + CNT_W'(1);
        if (miss_c && !(&miss_cnt_reg)) miss_cnt_next = miss_cnt_reg + CNT_W'(1);
        if (track && stall[gi] && !(&stall_cnt_reg))
          stall_cnt_next = stall_cnt_reg + CNT_W'(1);
        if (clr) begin
          state_next     = IDLE;
          lat_next       = '0;
          max_lat_next   = '0;
          req_cnt_next   = '0;
          miss_cnt_next  = '0;
          stall_cnt_next = '0;
        end
      end

      // Channel state registers; address history is tracked even when idle
      // or disabled so that re-enabling does not see a stale change.
      always_ff @(posedge clk) begin
        if (rst) begin
          addr_d_reg    <= '0;
          rst_d_reg     <= 1'b1;
          state_reg     <= IDLE;
          lat_reg       <= '0;
          max_lat_reg   <= '0;
          req_cnt_reg   <= '0;
          miss_cnt_reg  <= '0;
          stall_cnt_reg <= '0;
        end else begin
          addr_d_reg    <= addr_cur;
          rst_d_reg     <= 1'b0;
          state_reg     <= state_next;
          lat_reg       <= lat_next;
          max_lat_reg   <= max_lat_next;
          req_cnt_reg   <= req_cnt_next;
          miss_cnt_reg  <= miss_cnt_next;
          stall_cnt_reg <= stall_cnt_next;
        end
      end

      assign req[gi]  = req_c;
      assign hit[gi]  = hit_c;
      assign miss[gi] = miss_c;
      assign busy[gi] = (state_reg == MISS) & ~rst;

      assign req_cnt_flat[gi*CNT_W +: CNT_W]   = req_cnt_reg;
      assign miss_cnt_flat[gi*CNT_W +: CNT_W]  = miss_cnt_reg;
      assign stall_cnt_flat[gi*CNT_W +: CNT_W] = stall_cnt_reg;
      assign max_lat_flat[gi*LAT_W +: LAT_W]   = max_lat_reg;
    end
  endgenerate

  // Readout select; a channel index with no matching channel reads zero.
  always_comb begin
    rd_data_next = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_ch == RD_W'(i)) begin
        case (rd_sel)
          2'd0:    rd_data_next = req_cnt_flat[i*CNT_W +: CNT_W];
          2'd1:    rd_data_next = miss_cnt_flat[i*CNT_W +: CNT_W];
          2'd2:    rd_data_next = stall_cnt_flat[i*CNT_W +: CNT_W];
          default: rd_data_next = CNT_W'(max_lat_flat[i*LAT_W +: LAT_W]);
        endcase
      end
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (rst) rd_data_reg <= '0;
    else rd_data_reg <= rd_data_next;
  end

  assign rd_data = rd_data_reg;

endmodule

// File: tb/tb_cache_trace_stats.sv
// Directed bench for cache_trace_stats: default-size instance for function,
// small-width instance for latency and counter saturation.
module tb_cache_trace_stats;

  logic        clk;
  logic        rst;
  logic [1:0]  enable;
  logic        halt;
  logic        clr;
  logic [15:0] addr0, addr1;
  logic [31:0] addr;
  logic [1:0]  stall;
  logic [1:0]  req, hit, miss, busy;
  logic [0:0]  rd_ch;
  logic [1:0]  rd_sel;
  logic [15:0] rd_data;

  logic        s_rst;
  logic [1:0]  s_enable;
  logic        s_halt;
  logic        s_clr;
  logic [31:0] s_addr;
  logic [1:0]  s_stall;
  logic [1:0]  s_req, s_hit, s_miss, s_busy;
  logic [0:0]  s_rd_ch;
  logic [1:0]  s_rd_sel;
  logic [3:0]  s_rd_data;

  int tests = 0;
  int fails = 0;

  assign addr = {addr1, addr0};

  cache_trace_stats dut (
    .clk(clk), .rst(rst), .enable(enable), .halt(halt), .clr(clr),
    .addr(addr), .stall(stall), .req(req), .hit(hit), .miss(miss),
    .busy(busy), .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_data(rd_data)
  );

  cache_trace_stats #(.NCH(2), .ADDR_W(16), .CNT_W(4), .LAT_W(3)) dut_s (
    .clk(clk), .rst(s_rst), .enable(s_enable), .halt(s_halt), .clr(s_clr),
    .addr(s_addr), .stall(s_stall), .req(s_req), .hit(s_hit), .miss(s_miss),
    .busy(s_busy), .rd_ch(s_rd_ch), .rd_sel(s_rd_sel), .rd_data(s_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic rd_chk(input string tag, input logic [0:0] ch, input logic [1:0] sel,
                        input logic [31:0] exp);
    rd_ch  = ch;
    rd_sel = sel;
    step();
    look();
    chk(tag, {16'h0, rd_data}, exp);
  endtask

  task automatic s_rd_chk(input string tag, input logic [1:0] sel, input logic [31:0] exp);
    s_rd_ch  = 1'b0;
    s_rd_sel = sel;
    step();
    look();
    chk(tag, {28'h0, s_rd_data}, exp);
  endtask

  initial begin
    rst = 1'b1; enable = 2'b00; halt = 1'b0; clr = 1'b0;
    addr0 = '0; addr1 = '0; stall = 2'b00; rd_ch = '0; rd_sel = '0;
    s_rst = 1'b1; s_enable = 2'b00; s_halt = 1'b0; s_clr = 1'b0;
    s_addr = '0; s_stall = 2'b00; s_rd_ch = '0; s_rd_sel = '0;

    // Reset: outputs quiet, read port zero.
    step(); step(); look();
    chk("rst_req", {30'h0, req}, 32'h0);
    chk("rst_busy", {30'h0, busy}, 32'h0);
    chk("rst_rd_data", {16'h0, rd_data}, 32'h0);

    // First cycle after reset: both enabled channels see an access.
    step();
    rst = 1'b0; enable = 2'b11; addr0 = 16'h0000; addr1 = 16'h0010;
    look();
    chk("first_req", {30'h0, req}, 32'h3);
    chk("first_hit", {30'h0, hit}, 32'h3);
    chk("first_miss", {30'h0, miss}, 32'h0);
    step(); look();
    chk("same_addr_req", {30'h0, req}, 32'h0);
    rd_chk("ch0_req_cnt_1", 1'b0, 2'd0, 32'h1);

    // ch1 miss, stall held 4 cycles; address changes as stall drops.
    addr1 = 16'h0020; stall = 2'b10;
    look();
    chk("miss1_req", {30'h0, req}, 32'h2);
    chk("miss1_miss", {30'h0, miss}, 32'h2);
    chk("miss1_hit", {30'h0, hit}, 32'h0);
    step(); look();
    chk("miss1_busy", {30'h0, busy}, 32'h2);
    chk("miss1_req_in_miss", {30'h0, req}, 32'h0);
    step(); step(); step();
    stall = 2'b00; addr1 = 16'h0030;
    look();
    chk("drop_busy", {30'h0, busy}, 32'h2);
    chk("drop_addr_req", {30'h0, req}, 32'h0);
    step(); look();
    chk("after_drop_busy", {30'h0, busy}, 32'h0);
    chk("after_drop_req", {30'h0, req}, 32'h0);
    rd_chk("ch1_max_lat_4", 1'b1, 2'd3, 32'h4);
    rd_chk("ch1_stall_cnt_4", 1'b1, 2'd2, 32'h4);
    rd_chk("ch1_miss_cnt_1", 1'b1, 2'd1, 32'h1);
    rd_chk("ch1_req_cnt_2", 1'b1, 2'd0, 32'h2);

    // Shorter second miss leaves the maximum alone.
    addr1 = 16'h0040; stall = 2'b10;
    step(); step();
    stall = 2'b00;
    step();
    rd_chk("ch1_max_lat_still_4", 1'b1, 2'd3, 32'h4);

    // Longer third miss raises it.
    addr1 = 16'h0050; stall = 2'b10;
    for (int i = 0; i < 6; i++) step();
    stall = 2'b00;
    step();
    rd_chk("ch1_max_lat_6", 1'b1, 2'd3, 32'h6);
    rd_chk("ch1_stall_cnt_12", 1'b1, 2'd2, 32'hC);
    rd_chk("ch1_miss_cnt_3", 1'b1, 2'd1, 32'h3);
    rd_chk("ch1_req_cnt_4", 1'b1, 2'd0, 32'h4);
    rd_chk("ch0_req_cnt_still_1", 1'b0, 2'd0, 32'h1);

    // clr in the same cycle as a ch0 hit wipes everything.
    addr0 = 16'h0002; clr = 1'b1;
    look();
    chk("clr_hit", {30'h0, hit}, 32'h1);
    step();
    clr = 1'b0;
    look();
    chk("post_clr_req", {30'h0, req}, 32'h0);
    rd_chk("clr_ch0_req", 1'b0, 2'd0, 32'h0);
    rd_chk("clr_ch1_req", 1'b1, 2'd0, 32'h0);
    rd_chk("clr_ch1_stall", 1'b1, 2'd2, 32'h0);
    rd_chk("clr_ch1_max_lat", 1'b1, 2'd3, 32'h0);

    // Halt during a ch1 miss: freeze, FSM drops to IDLE, readout live.
    addr1 = 16'h0060; stall = 2'b10;
    step(); step();
    look();
    chk("pre_halt_busy", {30'h0, busy}, 32'h2);
    halt = 1'b1; addr0 = 16'h0003;
    look();
    chk("halt_req", {30'h0, req}, 32'h0);
    step();
    halt = 1'b0; addr0 = 16'h0004;
    look();
    chk("halted_busy", {30'h0, busy}, 32'h0);
    chk("halted_req", {30'h0, req}, 32'h0);
    chk("halted_hit", {30'h0, hit}, 32'h0);
    step(); step();
    rd_chk("frozen_ch1_stall", 1'b1, 2'd2, 32'h2);
    rd_chk("frozen_ch1_req", 1'b1, 2'd0, 32'h1);
    rd_chk("frozen_ch1_miss", 1'b1, 2'd1, 32'h1);
    rd_chk("frozen_ch1_max_lat", 1'b1, 2'd3, 32'h0);
    rd_chk("frozen_ch0_req", 1'b0, 2'd0, 32'h0);
    stall = 2'b00;

    // Reset releases the freeze.
    rst = 1'b1;
    step();
    rst = 1'b0;
    look();
    chk("post_halt_rst_req", {30'h0, req}, 32'h3);

    // Narrow instance: 20 hits saturate a 4-bit counter.
    s_rst = 1'b0; s_enable = 2'b01;
    for (int i = 0; i < 20; i++) begin
      s_addr = 32'(i);
      step();
    end
    s_rd_chk("s_req_cnt_sat", 2'd0, 32'hF);

    // 20-cycle stall saturates the 3-bit latency and the stall counter.
    s_addr = 32'd100; s_stall = 2'b01;
    for (int i = 0; i < 20; i++) step();
    s_stall = 2'b00;
    step();
    s_rd_chk("s_max_lat_sat", 2'd3, 32'h7);
    s_rd_chk("s_stall_cnt_sat", 2'd2, 32'hF);
    s_rd_chk("s_miss_cnt", 2'd1, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
